alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL provide parameter W, default 8, operand width in bits (legal 4..32).
REQ-002 SHALL provide clk_p_i  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL provide reset_n_i  input  1  asynchronous active-low reset.
REQ-004 SHALL provide valid_i  input  1  upstream command valid.
REQ-005 SHALL provide ready_o  output  1  block accepts command this cycle.
REQ-006 SHALL provide data_a_i  input  W  operand A.
REQ-007 SHALL provide data_b_i  input  W  operand B.
REQ-008 SHALL provide inst_i  input  4  opcode.
REQ-009 SHALL provide valid_o  output  1  result valid.
REQ-010 SHALL provide ready_i  input  1  downstream accepts result.
REQ-011 SHALL provide data_o  output  2W  result.
REQ-012 SHALL provide err_o  output  1  illegal opcode, qualified by valid_o.
REQ-013 SHALL provide ovf_o  output  1  accumulator saturated, qualified by valid_o.

Function
REQ-014 SHALL accept a command on a cycle with valid_i && ready_o high.
REQ-015 SHALL use two register stages (S1 operand/product, S2 output); an accepted result SHALL present valid_o exactly 2 cycles after acceptance absent stalls.
REQ-016 SHALL advance the pipe when ready_i || !valid_o; ready_o SHALL equal this advance term; stalled stages hold contents bit-exact.
REQ-017 SHALL sustain one command per cycle with ready_i tied high; no bubbles inserted, none dropped.
REQ-018 Opcodes: 0 ADD a+b zero-extended; 1 SUB a-b signed, sign-extended to 2W; 2 MUL unsigned a*b; 3 AND; 4 OR; 5 XOR (logic zero-extended); 6 SHL a<<b[log2(W)-1:0] into 2W; 7 MAX signed, sign-extended.
REQ-019 Opcode 8 MAC: accumulator (2W bits) += unsigned a*b at S1->S2 transfer; data_o = updated accumulator.
REQ-020 Opcode 9 ACCRD: data_o = accumulator value, accumulator cleared to 0 at same transfer.
REQ-021 Back-to-back MAC/ACCRD SHALL see the accumulator as updated by every earlier command (no hazard, no stall).
REQ-022 Opcodes 10..15 SHALL produce data_o=0, err_o=1, no accumulator change.
REQ-023 Accumulator SHALL change only when a MAC/ACCRD moves S1->S2, never during stall.
REQ-024 valid_o SHALL drop the cycle after a result is taken if no new result follows.

Reset
REQ-025 reset_n_i low SHALL immediately force valid_o=0, data_o=0, err_o=0, ovf_o=0, accumulator=0, S1 valid=0.
REQ-026 Reset mid-operation SHALL discard all in-flight commands; ready_o SHALL be 1 during and after reset.
REQ-027 First command SHALL be accepted on the first rising edge with reset_n_i high.

Configuration
REQ-028 With ALU_PIPE_SAT_EN defined, MAC overflow SHALL clamp accumulator to 2^(2W)-1 and assert ovf_o with that result.
REQ-029 Without ALU_PIPE_SAT_EN, MAC SHALL wrap modulo 2^(2W) and ovf_o SHALL be constant 0.

Structure
REQ-030 Package alu_pipe_pkg SHALL hold the opcode enumeration and opcode-count constant.
REQ-031 Combinational datapath SHALL be sub-module alu_pipe_ex (operands, opcode, accumulator in; result, err, ovf out); pipeline/handshake in alu_pipe.

Verification (W=8)
REQ-032 ADD a=0xFF b=0x01, ready_i=1 -> data_o=0x0100 valid 2 cycles later.
REQ-033 SUB a=0x01 b=0x02 then MUL 0xFF*0xFF -> 0xFFFF then 0xFE01, consecutive cycles.
REQ-034 MAC 3*4, MAC 5*6, ACCRD -> 0x000C, 0x002A, 0x002A; next MAC 1*1 -> 0x0001.
REQ-035 ready_i=0 for 5 cycles with 3 commands issued -> ready_o drops, outputs held, all 3 delivered in order after release.
REQ-036 Opcode 0xC -> data_o=0, err_o=1; with SAT_EN, MAC 0xFF*0xFF repeated until overflow -> data_o=0xFFFF, ovf_o=1.
REQ-037 reset_n_i pulsed low with 2 commands in flight -> valid_o=0 immediately, no stale result after release, accumulator=0.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// alu_pipe_pkg
// Shared opcode enumeration and opcode helpers for the two-stage ALU pipe.
// Opcodes 0..9 are defined; 10..15 are illegal and flagged with err_o.
// -----------------------------------------------------------------------------
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_MUL   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_XOR   = 4'd5,
        OP_SHL   = 4'd6,
        OP_MAX   = 4'd7,
        OP_MAC   = 4'd8,
        OP_ACCRD = 4'd9
    } op_e;

    localparam int NUM_OPS = 10;

    function automatic logic op_legal(input logic [3:0] op);
        return int'(op) < NUM_OPS;
    endfunction

    function automatic logic op_uses_acc(input logic [3:0] op);
        return (op == OP_MAC) || (op == OP_ACCRD);
    endfunction

endpackage

// File: rtl/alu_pipe_ex.sv
// -----------------------------------------------------------------------------
// alu_pipe_ex
// Purely combinational execute datapath that sits between the S1 and S2
// registers of alu_pipe.
//
// Ports
//   a_i, b_i   W-bit operands held in S1
//   op_i       4-bit opcode held in S1
//   acc_i      current 2W-bit accumulator
//   res_o      2W-bit result (for MAC this is also the next accumulator value)
//   err_o      illegal opcode
//   ovf_o      MAC saturated (only possible with ALU_PIPE_SAT_EN)
//
// Build option: ALU_PIPE_SAT_EN -- MAC clamps to all-ones on overflow and
// raises ovf_o; otherwise MAC wraps and ovf_o is tied low.
// -----------------------------------------------------------------------------
module alu_pipe_ex
    import alu_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    input  logic [3:0]     op_i,
    input  logic [2*W-1:0] acc_i,
    output logic [2*W-1:0] res_o,
    output logic           err_o,
    output logic           ovf_o
);

    localparam int SHW = $clog2(W);

    logic [2*W-1:0] a_z;
    logic [2*W-1:0] b_z;
    logic [2*W-1:0] a_s;
    logic [2*W-1:0] b_s;
    logic [2*W-1:0] prod;

    assign a_z  = {{W{1'b0}}, a_i};
    assign b_z  = {{W{1'b0}}, b_i};
    assign a_s  = {{W{a_i[W-1]}}, a_i};
    assign b_s  = {{W{b_i[W-1]}}, b_i};
    assign prod = a_z * b_z;

`ifdef ALU_PIPE_SAT_EN
    // One extra bit catches the carry out of the accumulator.
    logic [2*W:0] mac_sum;
    assign mac_sum = {1'b0, acc_i} + {1'b0, prod};
`else
    logic [2*W-1:0] mac_sum;
    assign mac_sum = acc_i + prod;
`endif

    always_comb begin
        res_o = '0;
        err_o = 1'b0;
        ovf_o = 1'b0;
        case (op_i)
            OP_ADD:   res_o = a_z + b_z;
            OP_SUB:   res_o = a_s - b_s;
            OP_MUL:   res_o = prod;
            OP_AND:   res_o = a_z & b_z;
            OP_OR:    res_o = a_z | b_z;
            OP_XOR:   res_o = a_z ^ b_z;
            OP_SHL:   res_o = a_z << b_i[SHW-1:0];
            OP_MAX:   res_o = ($signed(a_i) > $signed(b_i)) ? a_s : b_s;
            OP_MAC: begin
`ifdef ALU_PIPE_SAT_EN
                if (mac_sum[2*W]) begin
                    res_o = '1;
                    ovf_o = 1'b1;
                end else begin
                    res_o = mac_sum[2*W-1:0];
                end
`else
                res_o = mac_sum;
`endif
            end
            OP_ACCRD: res_o = acc_i;
            default:  err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Two-stage valid/ready ALU pipeline with a 2W-bit multiply-accumulator.
// S1 registers the accepted operands and opcode; alu_pipe_ex computes the
// result combinationally; S2 registers the result that drives the outputs.
// Both stages move together whenever the output is free (ready_i || !valid_o),
// and that same term is the upstream ready, so a full pipe stalls bit-exact
// and an empty or draining pipe never inserts bubbles.
//
// Ports
//   clk_p_i, reset_n_i    clock, asynchronous active-low reset
//   valid_i / ready_o     command handshake (data_a_i, data_b_i, inst_i)
//   valid_o / ready_i     result handshake (data_o, err_o, ovf_o)
//
// Build option: ALU_PIPE_SAT_EN -- saturating MAC with ovf_o reporting.
// -----------------------------------------------------------------------------
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk_p_i,
    input  logic           reset_n_i,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic [W-1:0]   data_a_i,
    input  logic [W-1:0]   data_b_i,
    input  logic [3:0]     inst_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [2*W-1:0] data_o,
    output logic           err_o,
    output logic           ovf_o
);

    logic           advance;

    logic           s1_valid_q, s1_valid_d;
    logic [W-1:0]   s1_a_q, s1_a_d;
    logic [W-1:0]   s1_b_q, s1_b_d;
    logic [3:0]     s1_op_q, s1_op_d;

    logic           s2_valid_q, s2_valid_d;
    logic [2*W-1:0] s2_data_q, s2_data_d;
    logic           s2_err_q, s2_err_d;
    logic           s2_ovf_q, s2_ovf_d;

    logic [2*W-1:0] acc_q, acc_d;

    logic [2*W-1:0] ex_res;
    logic           ex_err;
    logic           ex_ovf;

    alu_pipe_ex #(
        .W (W)
    ) u_ex (
        .a_i   (s1_a_q),
        .b_i   (s1_b_q),
        .op_i  (s1_op_q),
        .acc_i (acc_q),
        .res_o (ex_res),
        .err_o (ex_err),
        .ovf_o (ex_ovf)
    );

    always_comb begin
        advance    = ready_i || !s2_valid_q;

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_err_d   = s2_err_q;
        s2_ovf_d   = s2_ovf_q;
        acc_d      = acc_q;

        if (advance) begin
            s1_valid_d = valid_i;
            if (valid_i) begin
                s1_a_d  = data_a_i;
                s1_b_d  = data_b_i;
                s1_op_d = inst_i;
            end

            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = ex_res;
                s2_err_d  = ex_err;
                s2_ovf_d  = ex_ovf;
                // The accumulator moves in command order at the S1->S2
                // transfer, so the next MAC/ACCRD in S1 already sees it.
                if (op_uses_acc(s1_op_q)) begin
                    acc_d = (s1_op_q == OP_MAC) ? ex_res : '0;
                end
            end
        end
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_err_q   <= 1'b0;
            s2_ovf_q   <= 1'b0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_err_q   <= s2_err_d;
            s2_ovf_q   <= s2_ovf_d;
            acc_q      <= acc_d;
        end
    end

    assign ready_o = advance;
    assign valid_o = s2_valid_q;
    assign data_o  = s2_data_q;
    assign err_o   = s2_err_q;
    assign ovf_o   = s2_ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Scoreboarded bench for alu_pipe (W=8). Accepted commands are evaluated by an
// arithmetic reference model and queued; an independent monitor checks each
// presented result, its latency, and that stalled outputs hold steady.
// Honours ALU_PIPE_SAT_EN in the reference model.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int W = 8;
    localparam longint ACC_MAX = (longint'(1) << (2 * W)) - 1;

    logic           clk_p_i = 1'b0;
    logic           reset_n_i;
    logic           valid_i;
    logic           ready_o;
    logic [W-1:0]   data_a_i;
    logic [W-1:0]   data_b_i;
    logic [3:0]     inst_i;
    logic           valid_o;
    logic           ready_i;
    logic [2*W-1:0] data_o;
    logic           err_o;
    logic           ovf_o;

    alu_pipe #(.W(W)) dut (
        .clk_p_i   (clk_p_i),
        .reset_n_i (reset_n_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_a_i  (data_a_i),
        .data_b_i  (data_b_i),
        .inst_i    (inst_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .err_o     (err_o),
        .ovf_o     (ovf_o)
    );

    always #5 clk_p_i = ~clk_p_i;

    typedef struct {
        logic [2*W-1:0] data;
        logic           err;
        logic           ovf;
        int             cyc;
        int             stall;
        string          tag;
    } exp_t;

    exp_t   q[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     stall_cnt = 0;
    longint m_acc = 0;
    string  cur_tag = "init";
    bit     front_seen = 0;
    bit     hold_pending = 0;
    logic [2*W-1:0] hold_data;
    logic   hold_err, hold_ovf;
    bit     rnd_done = 0;

    always @(posedge clk_p_i) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on the operand values.
    function automatic void model(input int op, input int a, input int b,
                                  inout longint acc, output logic [2*W-1:0] d,
                                  output logic e, output logic o);
        longint sa, sb, r;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        e = 1'b0;
        o = 1'b0;
        r = 0;
        case (op)
            0: r = a + b;
            1: r = sa - sb;
            2: r = longint'(a) * b;
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = longint'(a) << (b % W);
            7: r = (sa > sb) ? sa : sb;
            8: begin
                acc = acc + longint'(a) * b;
`ifdef ALU_PIPE_SAT_EN
                if (acc > ACC_MAX) begin
                    acc = ACC_MAX;
                    o = 1'b1;
                end
`else
                acc = acc & ACC_MAX;
`endif
                r = acc;
            end
            9: begin
                r = acc;
                acc = 0;
            end
            default: begin
                e = 1'b1;
                r = 0;
            end
        endcase
        d = r[2*W-1:0];
    endfunction

    // Stimulus side of the scoreboard: record each accepted command.
    always @(negedge clk_p_i) begin
        if (reset_n_i && valid_i && ready_o) begin
            exp_t it;
            model(int'(inst_i), int'(data_a_i), int'(data_b_i), m_acc, it.data, it.err, it.ovf);
            it.cyc   = cyc;
            it.stall = stall_cnt;
            it.tag   = cur_tag;
            q.push_back(it);
        end
    end

    // Monitor: latency on first presentation, hold while stalled, data on transfer.
    always @(negedge clk_p_i) begin
        if (!reset_n_i) begin
            front_seen   = 0;
            hold_pending = 0;
        end else begin
            if (hold_pending) begin
                chk("hold_valid", valid_o, 1);
                chk("hold_data", data_o, hold_data);
                chk("hold_flags", {err_o, ovf_o}, {hold_err, hold_ovf});
                hold_pending = 0;
            end
            if (valid_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", valid_o, 0);
                end else begin
                    if (!front_seen) begin
                        chk({q[0].tag, "_latency"},
                            (cyc - q[0].cyc) - (stall_cnt - q[0].stall), 2);
                        front_seen = 1;
                    end
                    if (ready_i) begin
                        chk({q[0].tag, "_data"}, data_o, q[0].data);
                        chk({q[0].tag, "_err"}, err_o, q[0].err);
                        chk({q[0].tag, "_ovf"}, ovf_o, q[0].ovf);
                        void'(q.pop_front());
                        front_seen = 0;
                    end else begin
                        hold_pending = 1;
                        hold_data    = data_o;
                        hold_err     = err_o;
                        hold_ovf     = ovf_o;
                        stall_cnt++;
                    end
                end
            end
        end
    end

    // Drive a command at posedge+1 and keep it up until accepted.
    task automatic send(input string tag, input int op, input int a, input int b,
                        output int waited);
        bit acc;
        cur_tag  = tag;
        valid_i  = 1'b1;
        inst_i   = 4'(op);
        data_a_i = W'(a);
        data_b_i = W'(b);
        waited   = 0;
        forever begin
            @(negedge clk_p_i);
            acc = ready_o && reset_n_i;
            @(posedge clk_p_i);
            #1;
            if (acc) break;
            waited++;
            if (waited > 100) begin
                chk({tag, "_accept_timeout"}, waited, 0);
                break;
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || valid_o) && n < 200) begin
            @(posedge clk_p_i);
            #1;
            n++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    task automatic assert_reset(input string tag);
        valid_i   = 1'b0;
        reset_n_i = 1'b0;
        q.delete();
        m_acc     = 0;
        #1;
        chk({tag, "_valid_o"}, valid_o, 0);
        chk({tag, "_data_o"}, data_o, 0);
        chk({tag, "_err_o"}, err_o, 0);
        chk({tag, "_ovf_o"}, ovf_o, 0);
        chk({tag, "_ready_o"}, ready_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        reset_n_i = 1'b0;
        valid_i   = 1'b0;
        ready_i   = 1'b1;
        data_a_i  = '0;
        data_b_i  = '0;
        inst_i    = '0;
        #1;
        assert_reset("reset");
        repeat (2) @(posedge clk_p_i);
        #1;

        // First command goes in on the first edge after release.
        reset_n_i = 1'b1;
        send("add_ff_01", 0, 8'hFF, 8'h01, w);
        chk("first_accept_wait", w, 0);
        drain();

        send("sub_1_2", 1, 8'h01, 8'h02, w);
        send("mul_ff_ff", 2, 8'hFF, 8'hFF, w);
        drain();

        send("mac_3_4", 8, 3, 4, w);
        send("mac_5_6", 8, 5, 6, w);
        send("accrd", 9, 0, 0, w);
        send("mac_1_1", 8, 1, 1, w);
        send("accrd2", 9, 0, 0, w);
        drain();

        // Downstream stall with three commands.
        ready_i = 1'b0;
        fork
            begin
                repeat (5) @(posedge clk_p_i);
                #1;
                ready_i = 1'b1;
            end
        join_none
        send("stall_c1", 0, 8'h10, 8'h20, w);
        send("stall_c2", 5, 8'hA5, 8'h0F, w);
        @(negedge clk_p_i);
        chk("stall_ready_o", ready_o, 0);
        @(posedge clk_p_i);
        #1;
        send("stall_c3", 7, 8'h80, 8'h7F, w);
        drain();

        send("illegal_c", 4'hC, 8'h12, 8'h34, w);
        send("shl_3", 6, 8'h81, 8'h0B, w);
        send("max_neg", 7, 8'hFE, 8'hFD, w);

        // Saturating or wrapping MAC depending on build.
        send("sat_clr", 9, 0, 0, w);
        for (int i = 0; i < 3; i++) send("mac_ff_ff", 8, 8'hFF, 8'hFF, w);
        send("sat_rd", 9, 0, 0, w);
        drain();

        // Randomized traffic with random downstream back-pressure.
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk_p_i);
                    #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                end
                ready_i = 1'b1;
            end
        join_none
        for (int i = 0; i < 250; i++) begin
            int op;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_p_i);
                #1;
            end
            op = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 9) : $urandom_range(0, 15);
            send("rnd", op, $urandom_range(0, 255), $urandom_range(0, 255), w);
        end
        rnd_done = 1;
        repeat (3) @(posedge clk_p_i);
        #1;
        drain();

        // Reset with two commands in flight.
        send("pre_mac", 8, 2, 3, w);
        drain();
        send("fly_mac1", 8, 1, 1, w);
        send("fly_mac2", 8, 1, 1, w);
        assert_reset("midreset");
        repeat (3) @(posedge clk_p_i);
        #1;
        reset_n_i = 1'b1;
        send("post_reset_accrd", 9, 0, 0, w);
        chk("post_reset_accept_wait", w, 0);
        drain();
        repeat (4) @(posedge clk_p_i);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
